// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port data RAM: one access per grant via IDLE/ACCESS/DONE.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module ram_arbiter #(
  parameter  int unsigned DEPTH  = 1024,
  localparam int unsigned ADDR_W = $clog2(DEPTH),
  localparam int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_re_q, mem_re_d;
  logic              busy_q, busy_d;
  logic              win_c;
`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic              last_q, last_d;
`endif

  // Winner among the current requesters (only meaningful when some req is high)
  always_comb begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
    win_c = (req0 && req1) ? ~last_q : req1;
`else
    win_c = ~req0;
`endif
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    busy_d      = busy_q;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    last_d      = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          state_d     = ST_ACCESS;
          gnt_d       = win_c;
          mem_addr_d  = win_c ? addr1 : addr0;
          mem_wdata_d = win_c ? wdata1 : wdata0;
          mem_we_d    = win_c ? we1 : we0;
          mem_re_d    = win_c ? ~we1 : ~we0;
          busy_d      = 1'b1;
        end
      end
      ST_ACCESS: begin
        state_d = ST_DONE;
        busy_d  = 1'b1;
        // Read data is captured at the edge leaving ACCESS, while the RAM still sees the address
        if (mem_re_q) begin
          if (gnt_q) rdata1_d = mem_rdata;
          else       rdata0_d = mem_rdata;
        end
        ack0_d = ~gnt_q;
        ack1_d = gnt_q;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        last_d  = gnt_q;
`endif
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      busy_q      <= busy_d;
    end
  end

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // Port 0 wins the first tie after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`endif

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural async-read RAM attached.
module tb_ram_arbiter;
  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0, we0, req1, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [31:0]       wdata0, wdata1;
  logic              ack0, ack1;
  logic [31:0]       rdata0, rdata1;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic              mem_we, mem_re, busy;

  ram_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0003);
  endfunction

  // RAM model: async read, write on posedge, preloaded with pat()
  logic [31:0] ram [DEPTH];
  logic        ram_init;
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < int'(DEPTH); i++) ram[i] <= pat(i);
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
  end

  int cyc = 0;
  int we_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) we_cnt <= we_cnt + 1;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic        port;
    logic        rd;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  // Monitor: every ack pops the next expected completion
  logic [31:0] hold0 = '0;
  logic [31:0] hold1 = '0;
  initial begin
    exp_t e;
    logic [31:0] want;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold0 = '0;
        hold1 = '0;
      end else if (ack0 || ack1) begin
        if (ack0 && ack1) begin
          total++; bad++;
          $display("FAIL dual_ack: ack0=%b ack1=%b both high", ack0, ack1);
        end else if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ack: ack0=%b ack1=%b with nothing pending", ack0, ack1);
        end else begin
          e = exp_q.pop_front();
          chk("ack_port", {31'b0, ack1}, {31'b0, e.port});
          if (e.port) begin
            want = e.rd ? e.data : hold1;
            chk("rdata1", rdata1, want);
            chk("rdata0_hold", rdata0, hold0);
            hold1 = want;
          end else begin
            want = e.rd ? e.data : hold0;
            chk("rdata0", rdata0, want);
            chk("rdata1_hold", rdata1, hold1);
            hold0 = want;
          end
        end
      end
    end
  end

  // One transaction on one port; called at posedge+1 with the FSM in IDLE
  task automatic do_txn(input bit port, input bit we, input logic [ADDR_W-1:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, input int lat);
    int  c0;
    bit  got;
    c0 = cyc;
    exp_q.push_back('{port: port, rd: ~we, data: exp_rd});
    if (port) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    else      begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (port ? ack1 : ack0) got = 1'b1;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL ack_timeout: port %0d no ack within 20 cycles", port);
    end else begin
      chk("latency", 32'(cyc - c0), 32'(lat));
    end
    @(posedge clk); #1;
    if (port) req1 = 1'b0;
    else      req0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ram_init = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_ack0", {31'b0, ack0}, 32'd0);
    chk("rst_ack1", {31'b0, ack1}, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_re", {31'b0, mem_re}, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    ram_init = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;

    // Write then read back on port 0
    begin
      int wc0;
      wc0 = we_cnt;
      do_txn(1'b0, 1'b1, 10'd5, 32'hDEAD_BEEF, 32'h0, 2);
      chk("we_pulse_cycles", 32'(we_cnt - wc0), 32'd1);
      chk("ram5_written", ram[5], 32'hDEAD_BEEF);
    end
    do_txn(1'b0, 1'b0, 10'd5, 32'h0, 32'hDEAD_BEEF, 2);

    // Port 1 alone reads top address; port 0 data must hold
    do_txn(1'b1, 1'b0, 10'd1023, 32'h0, pat(1023), 2);
    chk("rdata0_after_p1", rdata0, 32'hDEAD_BEEF);

    // Continuous contention for four transaction slots
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'd10;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'd20;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    exp_q.push_back('{port: 1'b0, rd: 1'b1, data: pat(10)});
    exp_q.push_back('{port: 1'b1, rd: 1'b1, data: pat(20)});
    exp_q.push_back('{port: 1'b0, rd: 1'b1, data: pat(10)});
    exp_q.push_back('{port: 1'b1, rd: 1'b1, data: pat(20)});
`else
    for (int i = 0; i < 4; i++) exp_q.push_back('{port: 1'b0, rd: 1'b1, data: pat(10)});
`endif
    repeat (12) @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("contention_drained", 32'(exp_q.size()), 32'd0);

    // req1 raised while port 0 is in DONE: serviced next IDLE, ack 3 cycles later
    fork
      do_txn(1'b0, 1'b1, 10'd30, 32'h0BAD_F00D, 32'h0, 2);
      begin
        repeat (2) @(posedge clk); #1;
        do_txn(1'b1, 1'b0, 10'd30, 32'h0, 32'h0BAD_F00D, 3);
      end
    join

    // Back-to-back: req0 stays high through the ack edge, new fields form a new transaction
    do_txn(1'b0, 1'b0, 10'd5, 32'h0, 32'hDEAD_BEEF, 2);
    do_txn(1'b0, 1'b0, 10'd1023, 32'h0, pat(1023), 2);

    // Reset during ACCESS of a port-0 write to address 7
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'd7; wdata0 = 32'h1234_5678;
    @(posedge clk); #1;
    chk("abort_we_in_access", {31'b0, mem_we}, 32'd1);
    chk("abort_busy_in_access", {31'b0, busy}, 32'd1);
    #1;
    rst_n = 1'b0; req0 = 1'b0;
    #1;
    chk("abort_we_dropped", {31'b0, mem_we}, 32'd0);
    chk("abort_busy_dropped", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_ram7_unchanged", ram[7], pat(7));
    chk("abort_rdata0_cleared", rdata0, 32'd0);
    repeat (2) @(posedge clk); #1;
    // FSM back in IDLE: a fresh request sees normal latency
    do_txn(1'b1, 1'b0, 10'd7, 32'h0, pat(7), 2);

    repeat (2) @(posedge clk); #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
